// File: rtl/mips_dmem_pkg.sv
// Shared types and constants for the data-memory stage and its MMIO timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_dmem_pkg;

    // Word offsets inside the 16-byte MMIO window (address bits [3:2])
    localparam logic [1:0] MMIO_TIMER_CNT  = 2'd0;
    localparam logic [1:0] MMIO_TIMER_CMP  = 2'd1;
    localparam logic [1:0] MMIO_TIMER_CTRL = 2'd2;

    // Compare register powers up at all-ones so an enabled timer does not
    // match immediately after reset
    localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

    // Timer control word: bit0 en, bit1 reload, bit2 pend
    typedef struct packed {
        logic pend;
        logic reload;
        logic en;
    } timer_ctrl_t;

    // Zero-extend the control struct to a full read word
    function automatic logic [31:0] timer_ctrl_word(input timer_ctrl_t c);
        return {29'd0, c};
    endfunction

endpackage

// File: rtl/mips_dmem_if.sv
// Datapath-to-data-memory port bundle.
// Latency: read data is combinational from the address in the same cycle.
// Backpressure: none; the memory always accepts an access every cycle.
interface mips_dmem_if;

    logic [31:0] mem_daddr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        irq;

    // Datapath side drives the access, memory side returns data and interrupt
    modport master (
        output mem_daddr,
        output mem_wdata,
        output mem_we,
        output mem_be,
        input  mem_rdata,
        input  irq
    );

    modport slave (
        input  mem_daddr,
        input  mem_wdata,
        input  mem_we,
        input  mem_be,
        output mem_rdata,
        output irq
    );

endinterface

// File: rtl/mips_dmem_timer.sv
// Memory-mapped compare timer: CNT/CMP/CTRL registers, match detect, pending irq.
// Latency: register writes visible next cycle; irq follows the match edge by one cycle.
// Backpressure: none; every register access completes in its cycle.
module mips_dmem_timer
    import mips_dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_sel,
    input  logic        i_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

    logic [31:0] r_cnt;
    logic [31:0] r_cmp;
    timer_ctrl_t r_ctrl;

    logic        w_match;
    logic        w_wr_cnt;
    logic        w_wr_cmp;
    logic        w_wr_ctrl;
    timer_ctrl_t w_wr_val;
    logic [31:0] w_cnt_nxt;
    logic [31:0] w_cmp_nxt;
    timer_ctrl_t w_ctrl_nxt;

    // A match only counts while the timer is running
    assign w_match   = r_ctrl.en && (r_cnt == r_cmp);
    assign w_wr_cnt  = i_we && (i_sel == MMIO_TIMER_CNT);
    assign w_wr_cmp  = i_we && (i_sel == MMIO_TIMER_CMP);
    assign w_wr_ctrl = i_we && (i_sel == MMIO_TIMER_CTRL);
    assign w_wr_val  = timer_ctrl_t'(i_wdata[2:0]);

    // Next count: reload on match, else increment; a software write overrides both
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_ctrl.en) begin
            w_cnt_nxt = (w_match && r_ctrl.reload) ? 32'd0 : r_cnt + 32'd1;
        end
        if (w_wr_cnt) begin
            w_cnt_nxt = i_wdata;
        end
    end

    // Next compare value: only software changes it
    always_comb begin
        w_cmp_nxt = r_cmp;
        if (w_wr_cmp) begin
            w_cmp_nxt = i_wdata;
        end
    end

    // Next control: en/reload take the written value, pend is write-1-to-clear
    // but a match in the same cycle keeps it set
    always_comb begin
        w_ctrl_nxt = r_ctrl;
        if (w_wr_ctrl) begin
            w_ctrl_nxt.en     = w_wr_val.en;
            w_ctrl_nxt.reload = w_wr_val.reload;
            if (w_wr_val.pend) begin
                w_ctrl_nxt.pend = 1'b0;
            end
        end
        if (w_match) begin
            w_ctrl_nxt.pend = 1'b1;
        end
    end

    // Timer state registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 32'd0;
            r_cmp  <= TIMER_CMP_RST;
            r_ctrl <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_cmp  <= w_cmp_nxt;
            r_ctrl <= w_ctrl_nxt;
        end
    end

    // Register read mux; the reserved offset reads zero
    always_comb begin
        o_rdata = 32'd0;
        case (i_sel)
            MMIO_TIMER_CNT:  o_rdata = r_cnt;
            MMIO_TIMER_CMP:  o_rdata = r_cmp;
            MMIO_TIMER_CTRL: o_rdata = timer_ctrl_word(r_ctrl);
            default:         o_rdata = 32'd0;
        endcase
    end

    // pend is already a flop, so the level interrupt is taken straight from it
    assign o_irq = r_ctrl.pend;

endmodule

// File: rtl/mips_dmem.sv
// Data memory for the single-cycle core: byte-lane RAM plus a 16-byte MMIO window (timer when MIPS_DMEM_TIMER_EN is defined).
// Latency: reads combinational in the same cycle; writes land on the rising edge.
// Backpressure: none; one access accepted every cycle, RAM writes inhibited during reset.
module mips_dmem
    import mips_dmem_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic       clk,
    input  logic       rst,
    mips_dmem_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_ram [DEPTH];

    logic          w_mmio_hit;
    logic [AW-1:0] w_idx;
    logic          w_ram_we;
    logic [31:0]   w_mmio_rdata;
    logic          w_unused;

    // Window match ignores the low nibble; RAM index drops the byte offset and
    // everything above the array size, so RAM aliases modulo DEPTH words
    assign w_mmio_hit = (bus.mem_daddr[31:4] == MMIO_BASE[31:4]);
    assign w_idx      = bus.mem_daddr[AW+1:2];
    assign w_ram_we   = bus.mem_we && !w_mmio_hit && !rst;

    // Byte-lane RAM write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.mem_be[i]) begin
                    r_ram[w_idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef MIPS_DMEM_TIMER_EN
    logic w_tmr_we;

    // MMIO writes take the whole word; byte enables only matter for RAM
    assign w_tmr_we = bus.mem_we && w_mmio_hit;

    mips_dmem_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_sel   (bus.mem_daddr[3:2]),
        .i_we    (w_tmr_we),
        .i_wdata (bus.mem_wdata),
        .o_rdata (w_mmio_rdata),
        .o_irq   (bus.irq)
    );
`else
    // Window still decodes so MMIO writes never reach RAM; it reads as zero
    assign w_mmio_rdata = 32'd0;
    assign bus.irq      = 1'b0;
`endif

    // Byte offset bits are not needed by either target
    assign w_unused = ^bus.mem_daddr[1:0];

    // Read path is purely combinational from the address
    assign bus.mem_rdata = w_mmio_hit ? w_mmio_rdata : r_ram[w_idx];

endmodule

// File: tb/tb_mips_dmem.sv
// Self-checking bench for mips_dmem: random RAM traffic against a word-array model plus directed timer/reset steps.
// Latency: one access per clock; read data sampled on the falling edge, irq one step after the rising edge.
// Backpressure: none.
module tb_mips_dmem;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;

    logic clk = 1'b0;
    logic rst;

    initial forever #5 clk = ~clk;

    mips_dmem_if bus ();

    mips_dmem #(
        .DEPTH     (DEPTH),
        .MMIO_BASE (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          vectors = 0;
    int          errors  = 0;

    // Reference state
    logic [31:0] m_ram   [DEPTH];
    bit          m_valid [DEPTH];
    logic [31:0] m_cnt;
    logic [31:0] m_cmp;
    bit          m_en;
    bit          m_rld;
    bit          m_pend;
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_mmio(input logic [31:0] a);
        return (a >> 4) == (BASE >> 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'(DEPTH));
    endfunction

    function automatic bit known(input logic [31:0] a);
        return is_mmio(a) || m_valid[widx(a)];
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (is_mmio(a)) begin
`ifdef MIPS_DMEM_TIMER_EN
            case ((a >> 2) % 4)
                0:       return m_cnt;
                1:       return m_cmp;
                2:       return 32'(m_en) + 32'(m_rld) * 2 + 32'(m_pend) * 4;
                default: return 32'd0;
            endcase
`else
            return 32'd0;
`endif
        end
        return m_ram[widx(a)];
    endfunction

    function automatic logic [31:0] exp_irq();
`ifdef MIPS_DMEM_TIMER_EN
        return 32'(m_pend);
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset_timer();
        m_cnt  = 32'd0;
        m_cmp  = 32'hFFFF_FFFF;
        m_en   = 1'b0;
        m_rld  = 1'b0;
        m_pend = 1'b0;
    endtask

    // One bus cycle: drive, check read before the edge, advance model across the edge, check irq
    task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [3:0] be);
        logic [31:0] n_cnt;
        logic [31:0] n_cmp;
        logic [31:0] word;
        bit          n_en, n_rld, n_pend, hit;
        bus.mem_daddr = a;
        bus.mem_wdata = d;
        bus.mem_we    = we;
        bus.mem_be    = be;
        @(negedge clk);
        last_rd = bus.mem_rdata;
        if (known(a)) chk("rdata", last_rd, exp_read(a));
        // timer rules
        hit    = m_en && (m_cnt == m_cmp);
        n_cnt  = m_en ? ((hit && m_rld) ? 32'd0 : m_cnt + 32'd1) : m_cnt;
        n_cmp  = m_cmp;
        n_en   = m_en;
        n_rld  = m_rld;
        n_pend = m_pend || hit;
        if (we && is_mmio(a)) begin
            case ((a >> 2) % 4)
                0: n_cnt = d;
                1: n_cmp = d;
                2: begin
                    n_en  = d[0];
                    n_rld = d[1];
                    if (d[2] && !hit) n_pend = 1'b0;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        if (rst) begin
            model_reset_timer();
        end else begin
            m_cnt = n_cnt; m_cmp = n_cmp; m_en = n_en; m_rld = n_rld; m_pend = n_pend;
            if (we && !is_mmio(a)) begin
                word = m_ram[widx(a)];
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) word[8*i +: 8] = d[8*i +: 8];
                end
                m_ram[widx(a)] = word;
                if (be == 4'hF) m_valid[widx(a)] = 1'b1;
            end
        end
        #1;
        bus.mem_we = 1'b0;
        chk("irq", {31'd0, bus.irq}, exp_irq());
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        rst           = 1'b1;
        bus.mem_daddr = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = 4'h0;
        model_reset_timer();

        // Reset values
        #2;
        bus.mem_daddr = BASE;
        #1 chk("rst_cnt", bus.mem_rdata, exp_read(BASE));
        bus.mem_daddr = BASE + 32'd4;
        #1 chk("rst_cmp", bus.mem_rdata, exp_read(BASE + 32'd4));
        bus.mem_daddr = BASE + 32'd8;
        #1 chk("rst_ctrl", bus.mem_rdata, 32'd0);
        chk("rst_irq", {31'd0, bus.irq}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill RAM with known words
        for (int i = 0; i < DEPTH; i++) cycle(32'(i) * 4, $urandom, 1'b1, 4'hF);

        // Random traffic: RAM anywhere in the address space, occasional MMIO
        for (int n = 0; n < 300; n++) begin
            a    = $urandom;
            kind = $urandom_range(0, 7);
            if (kind == 0) a = BASE | (a & 32'h0000_000F);
            else if (is_mmio(a)) a[31] = 1'b0;
            cycle(a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom));
        end

        // Byte-lane merge
        cycle(32'h10, 32'hDEAD_BEEF, 1'b1, 4'hF);
        cycle(32'h10, 32'h0000_00AA, 1'b1, 4'b0001);
        cycle(32'h10, 32'd0, 1'b0, 4'h0);
        chk("byte_lane", last_rd, 32'hDEAD_BEAA);

        // Aliasing modulo DEPTH words
        cycle(32'h400, 32'h1234_5678, 1'b1, 4'hF);
        cycle(32'h0, 32'd0, 1'b0, 4'h0);
        chk("alias", last_rd, 32'h1234_5678);

`ifndef MIPS_DMEM_TIMER_EN
        // Window decodes but is inert
        cycle(BASE + 32'd8, 32'hFFFF_FFFF, 1'b1, 4'hF);
        cycle(BASE + 32'd8, 32'd0, 1'b0, 4'h0);
        chk("mmio_zero", last_rd, 32'd0);
        chk("mmio_irq", {31'd0, bus.irq}, 32'd0);
        cycle(32'h0, 32'd0, 1'b0, 4'h0);
        chk("mmio_no_alias", last_rd, 32'h1234_5678);
`else
        // Clean timer state
        rst = 1'b1;
        model_reset_timer();
        @(posedge clk);
        #1 rst = 1'b0;

        // Reload sequence: CNT 0..5 then 0, irq from the cycle after CNT==5
        cycle(BASE + 32'd4, 32'd5, 1'b1, 4'hF);
        cycle(BASE + 32'd8, 32'd3, 1'b1, 4'hF);
        for (int k = 0; k < 8; k++) begin
            cycle(BASE, 32'd0, 1'b0, 4'h0);
            chk("reload_seq", last_rd, (k <= 5) ? 32'(k) : 32'(k - 6));
            if (k == 4) chk("irq_low", {31'd0, bus.irq}, 32'd0);
            if (k == 5) chk("irq_rise", {31'd0, bus.irq}, 32'd1);
        end
        cycle(BASE + 32'd8, 32'd7, 1'b1, 4'hF);
        chk("irq_w1c", {31'd0, bus.irq}, 32'd0);
        cycle(BASE + 32'd8, 32'd0, 1'b0, 4'h0);
        chk("ctrl_after_w1c", last_rd, 32'd3);

        // Match coincident with write-1-to-clear keeps pend
        for (int g = 0; g < 20 && m_cnt != 32'd5; g++) cycle(BASE, 32'd0, 1'b0, 4'h0);
        cycle(BASE + 32'd8, 32'd7, 1'b1, 4'hF);
        chk("irq_match_w1c", {31'd0, bus.irq}, 32'd1);
        cycle(BASE + 32'd8, 32'd0, 1'b0, 4'h0);
        chk("pend_kept", last_rd, 32'd7);

        // Software write to CNT beats increment
        cycle(BASE, 32'd100, 1'b1, 4'hF);
        cycle(BASE, 32'd0, 1'b0, 4'h0);
        chk("cnt_wr", last_rd, 32'd100);
        cycle(BASE, 32'd0, 1'b0, 4'h0);
        chk("cnt_wr_inc", last_rd, 32'd101);

        // Run count up to 3 for the reset step
        cycle(BASE, 32'd0, 1'b1, 4'hF);
        for (int g = 0; g < 20 && m_cnt != 32'd3; g++) cycle(BASE, 32'd0, 1'b0, 4'h0);
        bus.mem_daddr = BASE;
        #1 chk("pre_rst_cnt", bus.mem_rdata, 32'd3);
`endif

        // Asynchronous reset mid-operation
        bus.mem_daddr = BASE;
        rst = 1'b1;
        model_reset_timer();
        #1 chk("arst_cnt", bus.mem_rdata, 32'd0);
        bus.mem_daddr = BASE + 32'd8;
        #1 chk("arst_ctrl", bus.mem_rdata, 32'd0);
        chk("arst_irq", {31'd0, bus.irq}, 32'd0);
        // RAM write attempted while in reset must not land
        cycle(32'h10, 32'hFFFF_FFFF, 1'b1, 4'hF);
        rst = 1'b0;
        cycle(32'h10, 32'd0, 1'b0, 4'h0);
        chk("ram_retained", last_rd, 32'hDEAD_BEAA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mips_dmem.md
# mips_dmem

Data-memory stage directly downstream of the single-cycle datapath's memory data port. Consumes `mem_daddr`/`mem_wdata` and a write strobe, and returns `mem_rdata` combinationally in the same cycle, as the single-cycle core requires. It holds a word-organised RAM with byte-lane writes and a small memory-mapped timer that raises an interrupt request on compare match.

## Interface
- `DEPTH`, 256: RAM size in 32-bit words; power of two.
- `MMIO_BASE`, 32'hFFFF_0000: base of the MMIO window; the window is 16 bytes.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `mem_daddr` in 32: byte address from the datapath.
- `mem_wdata` in 32: write data.
- `mem_we` in 1: write strobe (`ctrl` mem-write decode).
- `mem_be` in 4: byte enables; bit i gates byte lane `[8i+7:8i]`.
- `mem_rdata` out 32: read data, combinational from `mem_daddr`.
- `irq` out 1: timer interrupt request, level.

## Operation
- Address decode:
  - `mem_daddr[1:0]` ignored.
  - MMIO hit when `mem_daddr[31:4] == MMIO_BASE[31:4]`.
  - Otherwise RAM, index `mem_daddr[$clog2(DEPTH)+1:2]`. Higher bits ignored, so RAM aliases modulo DEPTH words.
- RAM behaviour:
  - Write on a clock edge with `mem_we`. Only lanes with `mem_be[i]=1` change.
  - Read is asynchronous; the full word is returned regardless of `mem_be`.
  - Contents are not reset.
- MMIO registers (offset = `mem_daddr[3:2]`). MMIO writes take the full word and ignore `mem_be`.
  - 0 `TIMER_CNT`: RW, 32 bit.
  - 1 `TIMER_CMP`: RW, 32 bit.
  - 2 `TIMER_CTRL`: bit0 `en`, bit1 `reload`, bit2 `pend`. `pend` reads as status; writing 1 to bit2 clears it, writing 0 leaves it unchanged. Bits 31:3 read 0.
  - 3: reserved. Reads 0; writes ignored.
- Timer counting:
  - While `en`=1, CNT increments by 1 each cycle and wraps 32'hFFFF_FFFF → 0.
  - A match is `en`=1 and CNT == CMP at the current edge. On a match, `pend` is set.
  - On a match with `reload`=1, next CNT = 0. On a match with `reload`=0, CNT keeps incrementing.
- `irq` = `pend`, registered.
- Simultaneous events:
  - Software write to CNT in the same cycle as an increment or reload: the written value wins.
  - Match in the same cycle as a write-1-to-clear of `pend`: `pend` stays set.
  - A CTRL write that sets `en` takes effect from the next cycle; no increment happens in the writing cycle.

## Timing
- Reset values: CNT=0, CMP=32'hFFFF_FFFF, CTRL=0, `irq`=0.
- `mem_rdata` is combinational and glitch-tolerant. RAM or MMIO write data is visible on reads from the cycle after the write edge.
- `irq` rises 1 cycle after the match edge, i.e. it is visible in the cycle after CNT==CMP was sampled.
- Asserting `rst` mid-operation:
  - Timer state clears immediately (asynchronous).
  - RAM writes are inhibited while `rst`=1.
  - RAM contents are retained.

## Configuration
- Macro: `MIPS_DMEM_TIMER_EN`.
- Defined: timer and `irq` as specified above.
- Undefined:
  - No timer logic is instantiated.
  - The MMIO window still decodes; all offsets read 0 and writes are ignored. MMIO writes never alias into RAM.
  - `irq` is tied to 0.

## Structure
- `mips_pkg` gains:
  - `MMIO_TIMER_CNT`/`CMP`/`CTRL` offset localparams.
  - `timer_ctrl_t` packed struct {`pend`, `reload`, `en`}.
- Sub-module `mips_dmem_timer`:
  - Holds the CNT/CMP/CTRL registers and the match logic.
  - Has a register-select, write-strobe and read-data port.
  - Instantiated only under `MIPS_DMEM_TIMER_EN`.
- The RAM array and address decode stay in `mips_dmem`.

## Test plan
- Byte-lane write:
  - Write 32'hDEAD_BEEF to 0x10 with be=4'hF, then 32'h0000_00AA with be=4'b0001.
  - Read of 0x10 → 32'hDEAD_BEAA.
- Aliasing: with DEPTH=256, write 32'h1234_5678 to 0x400 → read at 0x000 returns 32'h1234_5678.
- Timer reload:
  - Set CMP=5, then CTRL=3 (en, reload).
  - CNT goes 0..5, then 0. `irq` rises the cycle after CNT==5 and stays high.
  - Writing CTRL=32'h7 clears `pend` but leaves en/reload set; `irq` falls next cycle.
- Simultaneous events:
  - Force a match in the same cycle as a W1C of `pend` → `pend` stays 1.
  - Write CNT=100 during counting → next read of CNT is 100, or 101 one cycle later.
- Reset mid-count: assert `rst` at CNT=3 with `en`=1 → CNT=0, CTRL=0, `irq`=0 immediately; RAM word at 0x10 still reads back its pre-reset value.
- Macro undefined: write 32'hFFFF_FFFF to MMIO_BASE+8 → read returns 0, `irq` stays 0, and RAM word at 0x0 is unchanged.
